// File: rtl/bias_update_ctrl.sv
// -----------------------------------------------------------------------------
// bias_update_ctrl
//
// Bias-gradient step for the backprop output layer. A mini-batch of deltas is
// streamed in sample-major order (neuron 0..N_OUT-1 for sample 0, then sample
// 1, ...). One 20-bit gradient sum is kept per neuron. At the end of the batch
// each sum is scaled by ETA and added into the bias register bank, one neuron
// per cycle, and then done pulses for one cycle.
//
// Optional build macro: BIAS_SAT_EN
//   undefined : dcdb = prod[25:10], and the bias add wraps at 16 bits
//   defined   : dcdb = prod>>>10 saturated to 16 bits, and the bias add
//               saturates to [16'h8000, 16'h7FFF]
//
// Ports
//   clk          rising-edge clock
//   res          asynchronous active-low reset
//   start        begin a batch (sampled in IDLE only)
//   clr          synchronous abort back to IDLE; wins over start and transfers
//   delta_valid  delta_in carries a delta
//   delta_in     signed Q6.10 delta
//   delta_ready  high throughout ACC
//   init_we      bias preload strobe (IDLE only; idx >= N_OUT ignored)
//   init_idx     preload index
//   init_bias    preload value, signed Q6.10
//   rd_idx       read index
//   rd_bias      bias[rd_idx], combinational (0 for idx >= N_OUT)
//   busy         high in ACC and UPD
//   done         one-cycle completion pulse (DONE state)
//   state_dbg    current FSM state: 0 IDLE, 1 ACC, 2 UPD, 3 DONE
//
// Handshake: a delta transfer happens on a rising edge where delta_valid and
// delta_ready are both high and clr is low. delta_ready does not depend on
// delta_valid; the producer must hold delta_in stable while delta_valid is high
// and delta_ready is low.
// -----------------------------------------------------------------------------
module bias_update_ctrl #(
    parameter int                 N_OUT   = 2,
    parameter int                 N_BATCH = 4,
    parameter logic signed [15:0] ETA     = 16'hFF99
) (
    input  logic               clk,
    input  logic               res,
    input  logic               start,
    input  logic               clr,
    input  logic               delta_valid,
    input  logic signed [15:0] delta_in,
    output logic               delta_ready,
    input  logic               init_we,
    input  logic [3:0]         init_idx,
    input  logic signed [15:0] init_bias,
    input  logic [3:0]         rd_idx,
    output logic [15:0]        rd_bias,
    output logic               busy,
    output logic               done,
    output logic [1:0]         state_dbg
);

    localparam int IW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int SW = (N_BATCH > 1) ? $clog2(N_BATCH) : 1;
    localparam logic [IW-1:0] N_LAST  = IW'(N_OUT - 1);
    localparam logic [SW-1:0] S_LAST  = SW'(N_BATCH - 1);
    localparam logic [4:0]    N_OUT_W = 5'(N_OUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_UPD  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state, state_nx;

    logic signed [15:0] bias [N_OUT];
    logic signed [19:0] acc  [N_OUT];
    logic [IW-1:0]      n_idx;
    logic [SW-1:0]      s_idx;

    logic               accept;
    logic               last_n;
    logic               last_s;
    logic               init_hit;
    logic               rd_hit;

    logic signed [19:0] acc_sel;
    logic signed [15:0] bias_sel;
    logic signed [35:0] prod;
    logic signed [15:0] dcdb;
    logic signed [15:0] bias_new;

    assign accept   = (state == S_ACC) && delta_valid && !clr;
    assign last_n   = (n_idx == N_LAST);
    assign last_s   = (s_idx == S_LAST);
    assign init_hit = ({1'b0, init_idx} < N_OUT_W);
    assign rd_hit   = ({1'b0, rd_idx} < N_OUT_W);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = S_ACC;
            S_ACC:  if (accept && last_n && last_s) state_nx = S_UPD;
            S_UPD:  if (last_n) state_nx = S_DONE;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (clr) state_nx = S_IDLE;
    end

    always_comb begin
        delta_ready = (state == S_ACC);
        busy        = (state == S_ACC) || (state == S_UPD);
        done        = (state == S_DONE);
        state_dbg   = state;
    end

    // ---------------------------------------------------- gradient scaling
    always_comb begin
        acc_sel  = acc[n_idx];
        bias_sel = bias[n_idx];
        prod     = 36'(acc_sel) * 36'(ETA);
    end

`ifdef BIAS_SAT_EN
    logic signed [25:0] prod_q;
    logic signed [16:0] sum_w;
    logic               unused_prod_lsb;

    assign unused_prod_lsb = ^prod[9:0];

    always_comb begin
        prod_q = prod[35:10];
        if (prod_q > 26'sd32767) begin
            dcdb = 16'sh7FFF;
        end else if (prod_q < -26'sd32768) begin
            dcdb = 16'sh8000;
        end else begin
            dcdb = prod_q[15:0];
        end
        sum_w = {bias_sel[15], bias_sel} + {dcdb[15], dcdb};
        // The two top bits differ only when the 16-bit result overflowed.
        if (sum_w[16] != sum_w[15]) begin
            bias_new = sum_w[16] ? 16'sh8000 : 16'sh7FFF;
        end else begin
            bias_new = sum_w[15:0];
        end
    end
`else
    logic unused_prod_bits;

    assign unused_prod_bits = ^{prod[35:26], prod[9:0]};

    always_comb begin
        // Slicing an arithmetic product is a floor divide by 1024.
        dcdb     = prod[25:10];
        bias_new = bias_sel + dcdb;
    end
`endif

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            for (int i = 0; i < N_OUT; i++) begin
                bias[i] <= '0;
                acc[i]  <= '0;
            end
            n_idx <= '0;
            s_idx <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !clr) begin
                        for (int i = 0; i < N_OUT; i++) acc[i] <= '0;
                        n_idx <= '0;
                        s_idx <= '0;
                    end
                    if (init_we && init_hit) begin
                        bias[init_idx[IW-1:0]] <= init_bias;
                    end
                end
                S_ACC: begin
                    if (accept) begin
                        acc[n_idx] <= acc[n_idx] + 20'(delta_in);
                        if (last_n) begin
                            n_idx <= '0;
                            s_idx <= last_s ? '0 : s_idx + 1'b1;
                        end else begin
                            n_idx <= n_idx + 1'b1;
                        end
                    end
                end
                S_UPD: begin
                    if (!clr) begin
                        bias[n_idx] <= bias_new;
                        n_idx       <= last_n ? '0 : n_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------- read port
    always_comb begin
        rd_bias = '0;
        if (rd_hit) rd_bias = bias[rd_idx[IW-1:0]];
    end

endmodule

// File: tb/tb_bias_update_ctrl.sv
module tb_bias_update_ctrl;

  localparam int N_OUT   = 2;
  localparam int N_BATCH = 4;
  localparam int ETA_I   = -103;  // 16'hFF99

  // ---------------------------------------------------------- clock / reset
  logic clk = 1'b0;
  logic res = 1'b0;
  always #5 clk = ~clk;

  logic               start, clr, delta_valid, init_we;
  logic signed [15:0] delta_in, init_bias;
  logic [3:0]         init_idx, rd_idx;
  logic               delta_ready, busy, done;
  logic [15:0]        rd_bias;
  logic [1:0]         state_dbg;

  bias_update_ctrl #(.N_OUT(N_OUT), .N_BATCH(N_BATCH), .ETA(16'hFF99)) dut (
    .clk(clk), .res(res), .start(start), .clr(clr),
    .delta_valid(delta_valid), .delta_in(delta_in), .delta_ready(delta_ready),
    .init_we(init_we), .init_idx(init_idx), .init_bias(init_bias),
    .rd_idx(rd_idx), .rd_bias(rd_bias), .busy(busy), .done(done),
    .state_dbg(state_dbg)
  );

  // ------------------------------------------------------------ scoreboard
  logic [15:0]        exp_q[$];
  logic [15:0]        model_bias [N_OUT];
  logic signed [15:0] dq [N_BATCH][N_OUT];
  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: bias + floor(ETA*sum/1024), wrapped or saturated.
  function automatic logic [15:0] model_step(input logic [15:0] old_b, input longint sum);
    longint p, q, r;
    p = longint'(ETA_I) * sum;
    q = p >>> 10;
`ifdef BIAS_SAT_EN
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    r = longint'($signed(old_b)) + q;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
`else
    q = longint'($signed(q[15:0]));
    r = longint'($signed(old_b)) + q;
`endif
    return r[15:0];
  endfunction

  // ---------------------------------------------------------- driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    res = 1'b0;
    start = 0; clr = 0; delta_valid = 0; delta_in = '0;
    init_we = 0; init_idx = '0; init_bias = '0; rd_idx = '0;
    repeat (2) tick;
    res = 1'b1;
    tick;
    for (int n = 0; n < N_OUT; n++) model_bias[n] = '0;
    exp_q.delete();
  endtask

  task automatic init_write(input int idx, input logic [15:0] val);
    init_we = 1'b1; init_idx = 4'(idx); init_bias = val;
    tick;
    init_we = 1'b0;
    if (idx < N_OUT) model_bias[idx] = val;
  endtask

  task automatic fill_const(input logic [15:0] d0, input logic [15:0] d1);
    for (int s = 0; s < N_BATCH; s++) begin
      dq[s][0] = d0;
      dq[s][1] = d1;
    end
  endtask

  task automatic check_bank(input string tag);
    for (int n = 0; n < N_OUT; n++) begin
      rd_idx = 4'(n);
      #1;
      check_val(tag, rd_bias, model_bias[n]);
    end
  endtask

  // Full batch from dq; gaps of 1..max_gap idle cycles between transfers.
  task automatic run_batch(input string tag, input int max_gap, input bit poke_init);
    longint sum;
    int lat;
    for (int n = 0; n < N_OUT; n++) begin
      sum = 0;
      for (int s = 0; s < N_BATCH; s++) sum += longint'(dq[s][n]);
      model_bias[n] = model_step(model_bias[n], sum);
      exp_q.push_back(model_bias[n]);
    end
    rd_idx = '0;
    start = 1'b1;
    tick;
    start = 1'b0;
    check_val({tag, "_busy_acc"}, busy, 1);
    for (int s = 0; s < N_BATCH; s++) begin
      for (int n = 0; n < N_OUT; n++) begin
        if (max_gap > 0) begin
          delta_valid = 1'b0;
          if (poke_init && s == 0 && n == 1) begin
            init_we = 1'b1; init_idx = 4'd1; init_bias = 16'h7777;
          end
          repeat ($urandom_range(1, max_gap)) begin
            tick;
            check_val({tag, "_ready_gap"}, delta_ready, 1);
          end
          init_we = 1'b0;
        end
        delta_valid = 1'b1;
        delta_in = dq[s][n];
        tick;
      end
    end
    delta_valid = 1'b0;
    lat = 0;
    while (!done && lat < 10) begin
      tick;
      lat++;
      if (lat == 1) check_val({tag, "_bias0_first_edge"}, rd_bias, exp_q[0]);
    end
    check_val({tag, "_done_latency"}, lat, N_OUT);
    tick;
    check_val({tag, "_done_width"}, done, 0);
    check_val({tag, "_idle_busy"}, busy, 0);
    for (int n = 0; n < N_OUT; n++) begin
      rd_idx = 4'(n);
      #1;
      check_val({tag, "_bias"}, rd_bias, exp_q.pop_front());
    end
  endtask

  // -------------------------------------------------------------- stimulus
  initial begin
    do_reset;
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_ready", delta_ready, 0);
    check_val("rst_state", state_dbg, 0);
    check_bank("rst_bias");

    // Out-of-range preload is ignored.
    init_write(5, 16'h1234);
    check_bank("init_oob");

    // Basic update.
    fill_const(16'h0400, 16'h0000);
    run_batch("basic", 0, 0);
    rd_idx = 4'd0; #1; check_val("basic_b0_const", rd_bias, 16'hFE64);
    rd_idx = 4'd1; #1; check_val("basic_b1_const", rd_bias, 16'h0000);

    // Backpressure gaps; a preload attempt during ACC must be ignored.
    do_reset;
    run_batch("gaps", 3, 1);
    rd_idx = 4'd0; #1; check_val("gaps_b0_const", rd_bias, 16'hFE64);
    rd_idx = 4'd1; #1; check_val("gaps_b1_const", rd_bias, 16'h0000);

    // Preload plus negative deltas; neuron 1 gets random data.
    do_reset;
    init_write(0, 16'h0400);
    fill_const(16'hFC00, 16'h0000);
    for (int s = 0; s < N_BATCH; s++) dq[s][1] = 16'($urandom_range(0, 16'hFFFF));
    run_batch("neg", 1, 0);
    rd_idx = 4'd0; #1; check_val("neg_b0_const", rd_bias, 16'h059C);

    // Overflow of the bias add.
    do_reset;
    init_write(0, 16'h8010);
    fill_const(16'h2000, 16'h0000);
    run_batch("ovf", 0, 0);
    rd_idx = 4'd0; #1;
`ifdef BIAS_SAT_EN
    check_val("ovf_b0_const", rd_bias, 16'h8000);
`else
    check_val("ovf_b0_const", rd_bias, 16'h7330);
`endif

    // Random batches on top of the current biases.
    for (int k = 0; k < 3; k++) begin
      for (int s = 0; s < N_BATCH; s++)
        for (int n = 0; n < N_OUT; n++) dq[s][n] = 16'($urandom_range(0, 16'hFFFF));
      run_batch("rand", 2, 0);
    end

    // Abort after 5 accepted deltas, then a clean batch.
    init_write(0, 16'h0000);
    init_write(1, 16'h0000);
    check_bank("abort_pre");
    fill_const(16'h0400, 16'h0400);
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int t = 0; t < 5; t++) begin
      delta_valid = 1'b1; delta_in = 16'h0400;
      tick;
    end
    delta_valid = 1'b1;
    clr = 1'b1;
    tick;
    clr = 1'b0;
    delta_valid = 1'b0;
    check_val("abort_state", state_dbg, 0);
    check_val("abort_busy", busy, 0);
    repeat (4) begin
      tick;
      check_val("abort_no_done", done, 0);
    end
    check_bank("abort_bias");
    fill_const(16'h0400, 16'h0000);
    run_batch("after_abort", 0, 0);
    rd_idx = 4'd0; #1; check_val("after_abort_b0_const", rd_bias, 16'hFE64);

    // Reset in the middle of UPD.
    do_reset;
    rd_idx = 4'd0;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int s = 0; s < N_BATCH; s++)
      for (int n = 0; n < N_OUT; n++) begin
        delta_valid = 1'b1; delta_in = dq[s][n];
        tick;
      end
    delta_valid = 1'b0;
    tick;
    check_val("mid_upd_b0_written", rd_bias, 16'hFE64);
    check_val("mid_upd_busy", busy, 1);
    #2;
    res = 1'b0;
    start = 1'b1;
    #1;
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_done", done, 0);
    check_val("mid_rst_ready", delta_ready, 0);
    check_bank("mid_rst_bias");
    repeat (3) begin
      tick;
      check_val("rst_held_start", busy, 0);
    end
    res = 1'b1;
    start = 1'b0;
    tick;
    check_val("rst_release_state", state_dbg, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bias_update_ctrl.md
Name: bias_update_ctrl

Overview:
- Sequences the bias-gradient step of the backprop output layer for a mini-batch.
- Accepts a stream of delta values, accumulates one gradient sum per output neuron over N_BATCH samples, and scales each sum by eta.
- Applies the result to an internal bias register bank, one neuron per cycle, then pulses done.
- Sits between the delta-generation stage and the forward-pass bias readers. It owns the bias state and the sample/neuron counters.

Parameters:
- N_OUT, 2, number of output neurons / bias registers (1..16)
- N_BATCH, 4, samples per update window (1..16)
- ETA, 16'hFF99, signed Q6.10 learning rate (negative; -0.1006)

Ports:
- clk  in  1  rising-edge clock
- res  in  1  reset, asynchronous, active-low
- start  in  1  begin a batch; sampled only in IDLE
- clr  in  1  synchronous abort; returns to IDLE without any bias write
- delta_valid  in  1  delta_in is valid
- delta_in  in  16  signed Q6.10 delta
- delta_ready  out  1  block accepts delta this cycle
- init_we  in  1  bias preload strobe; honoured only in IDLE
- init_idx  in  4  bias index for preload
- init_bias  in  16  signed Q6.10 preload value
- rd_idx  in  4  bias read index
- rd_bias  out  16  bias[rd_idx], combinational read of current register
- busy  out  1  high in ACC and UPD
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (res=0): state IDLE; all biases, accumulators and counters 0; delta_ready=0, busy=0, done=0. Reset takes effect immediately, including mid-batch; there is no partial write-back.
- FSM states: IDLE, ACC, UPD, DONE.
- IDLE:
  - start=1 -> ACC; clears all accumulators, n_idx and s_idx.
  - init_we writes bias[init_idx]; indices >= N_OUT are ignored.
- ACC:
  - delta_ready=1. A transfer occurs on delta_valid & delta_ready.
  - Ordering is sample-major: neuron 0..N_OUT-1 for sample 0, then sample 1, and so on.
  - acc[n_idx] += sign-extended delta_in. Accumulators are 20-bit signed; no overflow is possible within the allowed ranges.
  - n_idx wraps at N_OUT-1 and increments s_idx.
  - Accepting the transfer with n_idx=N_OUT-1 and s_idx=N_BATCH-1 -> UPD, n_idx=0.
  - While valid is low, counters and accumulators hold.
- UPD:
  - delta_ready=0. One neuron per cycle, i = 0..N_OUT-1.
  - prod = ETA * acc[i], 36-bit signed.
  - dcdb = prod[25:10] (Q6.10, truncation toward -inf).
  - bias[i] <= bias[i] + dcdb, 16-bit wrap.
  - After i = N_OUT-1 -> DONE.
- DONE: done=1 for exactly one cycle, then -> IDLE.
- Latency: bias[i] is written on the (i+1)th edge after the last accepting edge; done is high in cycle N_OUT+1 after that edge.
- clr=1 in ACC/UPD/DONE -> IDLE next edge. Biases already written in UPD keep their values; done is not pulsed.
- clr has priority over start and delta transfer. start in non-IDLE states is ignored. init_we outside IDLE is ignored.
- Simultaneous start and init_we in IDLE: both take effect.
- rd_bias reflects the register after every edge, including mid-UPD.

Optional Feature:
- Macro: BIAS_SAT_EN.
- Defined: dcdb saturates prod>>10 to [16'h8000, 16'h7FFF] rather than slicing. The bias add saturates to the same range.
- Undefined: dcdb uses the slice and the add wraps as above.

Test Plan:
- Basic update: N_OUT=2, N_BATCH=4; biases 0; neuron0 deltas 4x 16'h0400, neuron1 deltas 4x 16'h0000 -> bias0 = 16'hFE64, bias1 = 16'h0000; done one cycle, 3 cycles after the last accept.
- Backpressure gaps: same data with delta_valid low for 1-3 random cycles between transfers -> identical results; delta_ready stays 1 throughout ACC.
- Preload plus negative deltas: init bias0 = 16'h0400, neuron0 deltas 4x 16'hFC00 -> acc = -4096, bias0 = 16'h0400 + 16'h019C = 16'h059C.
- Overflow: init bias0 = 16'h8010, neuron0 deltas 4x 16'h2000 -> dcdb = 16'hF320; bias0 = 16'h7330 without BIAS_SAT_EN, 16'h8000 with it.
- Abort: clr after 5 accepted deltas -> IDLE, biases unchanged, no done. A following full batch behaves as in the basic-update scenario (accumulators cleared).
- Reset mid-UPD: res low after bias0 written -> all biases 0, busy=0, done=0; start ignored while res is low.
